stream_fifo: RTL and testbench
==============================

# stream_fifo

Parametrised valid/ready stream buffer between a producing block and a consuming block, replacing the plain point-to-point wire bundle with a decoupled, back-pressured channel. It holds up to DEPTH words of DATA_W bits, presents first-word-fall-through output, and reports fill level and an almost-full flag. It sits behind the stream interface's sink modport on its input side and the source modport on its output side, so DUT and bench connect through the interface exactly as before.

## Interface
- DATA_W, 8, payload width in bits (≥1)
- DEPTH, 4, storage words; power of two, ≥2
- AF_LEVEL, DEPTH-1, almost_full asserts when count ≥ AF_LEVEL (1..DEPTH)
- CNT_W, $clog2(DEPTH)+1, derived, width of count; not to be overridden
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- flush  input  1  synchronous clear of contents, same effect as rst on state
- in_valid  input  1  producer has a word on in_data
- in_data  input  DATA_W  write payload
- in_ready  output  1  FIFO accepts a word this cycle
- out_valid  output  1  out_data holds the oldest stored word
- out_data  output  DATA_W  read payload
- out_ready  input  1  consumer takes the word this cycle
- count  output  CNT_W  words currently stored, 0..DEPTH
- almost_full  output  1  count ≥ AF_LEVEL

Input-side ports form the sink modport (in_valid/in_data input, in_ready output); output-side ports form the source modport (out_valid/out_data output, out_ready input). Reset is synchronous and active-high on rst, single clock clk.

## Operation
- Storage: DEPTH×DATA_W register array, write pointer wr_ptr and read pointer rd_ptr, each $clog2(DEPTH) bits, wrap naturally modulo DEPTH.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count != DEPTH) & ~rst & ~flush (combinational from registered count plus control inputs).
- out_valid = (count != 0); out_data = mem[rd_ptr] when out_valid, all zeros when empty.
- On push: mem[wr_ptr] ← in_data, wr_ptr ← wr_ptr+1.
- On pop: rd_ptr ← rd_ptr+1.
- count update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Full: in_ready=0; in_valid ignored, data not written; no pass-through of a same-cycle pop into a push.
- Empty: out_valid=0; no pop possible; a word pushed while empty is not visible until the next cycle (no combinational bypass).
- Simultaneous push and pop with 0 < count < DEPTH: both pointers advance, count unchanged, order preserved.
- Producer rule: in_data must be held stable while in_valid=1 and in_ready=0; FIFO does not check this.
- rst or flush (rst has priority, identical effect): wr_ptr, rd_ptr, count ← 0; memory contents not cleared; any push/pop in that cycle discarded.
- Reset or flush mid-operation discards all stored words; first word accepted afterwards is the first word read.

## Timing
- Reset values (cycle after rst sampled high): count=0, out_valid=0, out_data=0, almost_full=0 (AF_LEVEL≥1); in_ready=0 while rst high, 1 in first cycle after rst deasserts.
- Write-to-read latency: word pushed at edge N is on out_data with out_valid=1 in cycle after edge N.
- Throughput: one push and one pop per cycle sustained.
- count and almost_full reflect state after the most recent edge; almost_full is registered-state-derived, no combinational path from in_valid/out_ready.
- Only combinational input-to-output paths: rst/flush → in_ready.

## Test plan
- Reset: hold rst 2 cycles with in_valid=1, in_data=8'hAA → count=0, out_valid=0, out_data=0, in_ready=0 during reset, 1 after; nothing stored.
- Fill/drain, DEPTH=4: push 8'h11,22,33,44 with out_ready=0 → count 4, in_ready=0, almost_full=1 from count 3; fifth word 8'h55 rejected; then out_ready=1 → reads 11,22,33,44 in 4 cycles, out_valid=0 after.
- Streaming: in_valid=1 and out_ready=1 continuous, data 0..15 → output 0..15 in order, one cycle after each push, count settles at 1.
- Full boundary: at count=4, assert in_valid (8'h66) and out_ready together → pop of head only, count 3, 8'h66 not written; next cycle push accepted.
- Wrap-around: 3 pushes, 3 pops, then 4 pushes of A0..A3 → pointers wrap, reads return A0..A3, count tracks 0..4 correctly.
- Flush mid-operation: with count=3, pulse flush with in_valid=1 (8'h77) → count=0, out_valid=0, 8'h77 discarded; next pushed 8'h88 is next read.

Source files
------------

// File: rtl/stream_fifo.sv
// First-word-fall-through valid/ready FIFO with fill count and almost-full flag.
// Synchronous active-high reset; flush clears pointers and count the same way.
module stream_fifo #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  count,
  output logic              almost_full
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push, pop;

  assign in_ready    = (count_q != CNT_W'(DEPTH)) & ~rst & ~flush;
  assign out_valid   = (count_q != '0);
  assign out_data    = out_valid ? mem_q[rd_ptr_q] : '0;
  assign count       = count_q;
  assign almost_full = (count_q >= CNT_W'(AF_LEVEL));

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never cleared; push is already masked by rst/flush.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: tb/tb_stream_fifo.sv
// Directed vector bench for stream_fifo (DEPTH=4, DATA_W=8, AF_LEVEL=3).
// Each vector: inputs for one cycle and outputs expected before its edge.
module tb_stream_fifo;

  logic       clk = 1'b0;
  logic       rst, flush, in_valid, in_ready;
  logic       out_valid, out_ready, almost_full;
  logic [7:0] in_data, out_data;
  logic [2:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stream_fifo #(.DATA_W(8), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .count      (count),
    .almost_full(almost_full)
  );

  typedef struct {
    logic       rst;
    logic       flush;
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic [2:0] cnt;
    logic       ov;
    logic [7:0] od;
    logic       ir;
    logic       af;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic f, input logic iv,
                     input logic [7:0] d, input logic ordy,
                     input logic [2:0] cnt, input logic ov,
                     input logic [7:0] od, input logic ir, input logic af);
    vec_t v;
    v.rst = r; v.flush = f; v.iv = iv; v.d = d; v.ordy = ordy;
    v.cnt = cnt; v.ov = ov; v.od = od; v.ir = ir; v.af = af;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input int step,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic iv,
                       input logic [7:0] d, input logic ordy);
    @(negedge clk);
    rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
    #4;
  endtask

  task automatic check_all(input int step, input logic [2:0] cnt,
                           input logic ov, input logic [7:0] od,
                           input logic ir, input logic af);
    check("count", step, 32'(count), 32'(cnt));
    check("out_valid", step, 32'(out_valid), 32'(ov));
    check("out_data", step, 32'(out_data), 32'(od));
    check("in_ready", step, 32'(in_ready), 32'(ir));
    check("almost_full", step, 32'(almost_full), 32'(af));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1;
    in_data = 8'hAA; out_ready = 1'b0;

    //  rst fl iv d      or  cnt ov od     ir af
    // second reset cycle, then release
    add(1, 0, 1, 8'hAA, 0, 0, 0, 8'h00, 0, 0);
    add(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0);
    // fill
    add(0, 0, 1, 8'h11, 0, 0, 0, 8'h00, 1, 0);
    add(0, 0, 1, 8'h22, 0, 1, 1, 8'h11, 1, 0);
    add(0, 0, 1, 8'h33, 0, 2, 1, 8'h11, 1, 0);
    add(0, 0, 1, 8'h44, 0, 3, 1, 8'h11, 1, 1);
    add(0, 0, 1, 8'h55, 0, 4, 1, 8'h11, 0, 1);
    // full: push+pop -> pop only
    add(0, 0, 1, 8'h66, 1, 4, 1, 8'h11, 0, 1);
    add(0, 0, 1, 8'h66, 1, 3, 1, 8'h22, 1, 1);
    add(0, 0, 0, 8'h00, 1, 3, 1, 8'h33, 1, 1);
    add(0, 0, 0, 8'h00, 1, 2, 1, 8'h44, 1, 0);
    add(0, 0, 0, 8'h00, 1, 1, 1, 8'h66, 1, 0);
    add(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0);
    // wrap-around
    add(0, 0, 1, 8'hB0, 0, 0, 0, 8'h00, 1, 0);
    add(0, 0, 1, 8'hB1, 0, 1, 1, 8'hB0, 1, 0);
    add(0, 0, 1, 8'hB2, 0, 2, 1, 8'hB0, 1, 0);
    add(0, 0, 0, 8'h00, 1, 3, 1, 8'hB0, 1, 1);
    add(0, 0, 0, 8'h00, 1, 2, 1, 8'hB1, 1, 0);
    add(0, 0, 0, 8'h00, 1, 1, 1, 8'hB2, 1, 0);
    add(0, 0, 1, 8'hA0, 0, 0, 0, 8'h00, 1, 0);
    add(0, 0, 1, 8'hA1, 0, 1, 1, 8'hA0, 1, 0);
    add(0, 0, 1, 8'hA2, 0, 2, 1, 8'hA0, 1, 0);
    add(0, 0, 1, 8'hA3, 0, 3, 1, 8'hA0, 1, 1);
    add(0, 0, 0, 8'h00, 1, 4, 1, 8'hA0, 0, 1);
    add(0, 0, 0, 8'h00, 1, 3, 1, 8'hA1, 1, 1);
    add(0, 0, 0, 8'h00, 1, 2, 1, 8'hA2, 1, 0);
    add(0, 0, 0, 8'h00, 1, 1, 1, 8'hA3, 1, 0);
    add(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0);
    // flush mid-operation
    add(0, 0, 1, 8'h01, 0, 0, 0, 8'h00, 1, 0);
    add(0, 0, 1, 8'h02, 0, 1, 1, 8'h01, 1, 0);
    add(0, 0, 1, 8'h03, 0, 2, 1, 8'h01, 1, 0);
    add(0, 1, 1, 8'h77, 0, 3, 1, 8'h01, 0, 1);
    add(0, 0, 1, 8'h88, 0, 0, 0, 8'h00, 1, 0);
    add(0, 0, 0, 8'h00, 1, 1, 1, 8'h88, 1, 0);
    add(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0);

    // first reset cycle: state unknown, only in_ready is defined
    drive(1, 0, 1, 8'hAA, 0);
    check("in_ready_rst", -1, 32'(in_ready), 32'd0);

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].flush, vq[i].iv, vq[i].d, vq[i].ordy);
      check_all(i, vq[i].cnt, vq[i].ov, vq[i].od, vq[i].ir, vq[i].af);
    end

    // streaming: continuous push+pop, output trails input by one cycle
    for (int k = 0; k < 16; k++) begin
      drive(0, 0, 1, 8'(k), 1);
      if (k == 0) check_all(100, 0, 0, 8'h00, 1, 0);
      else        check_all(100 + k, 1, 1, 8'(k - 1), 1, 0);
    end
    drive(0, 0, 0, 8'h00, 1);
    check_all(116, 1, 1, 8'h0F, 1, 0);
    drive(0, 0, 0, 8'h00, 0);
    check_all(117, 0, 0, 8'h00, 1, 0);

    // reset mid-operation with a pop requested
    drive(0, 0, 1, 8'hC1, 0);
    drive(0, 0, 1, 8'hC2, 0);
    check_all(118, 1, 1, 8'hC1, 1, 0);
    drive(1, 0, 1, 8'hC3, 1);
    check_all(119, 2, 1, 8'hC1, 0, 0);
    drive(0, 0, 1, 8'hC4, 0);
    check_all(120, 0, 0, 8'h00, 1, 0);
    drive(0, 0, 0, 8'h00, 1);
    check_all(121, 1, 1, 8'hC4, 1, 0);
    drive(0, 0, 0, 8'h00, 0);
    check_all(122, 0, 0, 8'h00, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
